// File: rtl/udp_rx.sv
// UDP/IPv4 receive parser: strips preamble, Ethernet, IPv4 and UDP headers from a GMII byte
// stream, filters on MAC/IP/port, verifies the IPv4 header checksum and packs payload into words.
module udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic [31:0] fifo_din,
  output logic        fifo_wren,
  input  logic        fifo_full,
  output logic [15:0] rx_data_length,
  output logic        rx_done,
  output logic        rx_err,
  output logic [3:0]  rx_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_ETH      = 4'd2,
    S_IPHDR    = 4'd3,
    S_UDPHDR   = 4'd4,
    S_DATA     = 4'd5,
    S_DROP     = 4'd6
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] pay_len_q, pay_len_d;
  logic [15:0] data_len_q, data_len_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] word_q, word_d;
  logic        wr_pend_q, wr_pend_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [19:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        mac_ok_q, mac_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic        ok_q, ok_d;

  logic        byte_ok, wr_block;
  logic [4:0]  cnt_inc;
  logic [15:0] pay_inc;
  logic [31:0] shifted;
  logic [19:0] csum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    case (i)
      3'd0:    return LOCAL_MAC[47:40];
      3'd1:    return LOCAL_MAC[39:32];
      3'd2:    return LOCAL_MAC[31:24];
      3'd3:    return LOCAL_MAC[23:16];
      3'd4:    return LOCAL_MAC[15:8];
      3'd5:    return LOCAL_MAC[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] i);
    case (i)
      2'd0:    return LOCAL_IP[31:24];
      2'd1:    return LOCAL_IP[23:16];
      2'd2:    return LOCAL_IP[15:8];
      default: return LOCAL_IP[7:0];
    endcase
  endfunction

  // A write is due whenever wr_pend_q is set; a full FIFO at that moment kills the frame.
  assign wr_block       = wr_pend_q & fifo_full;
  assign fifo_wren      = wr_pend_q & ~fifo_full;
  assign rx_done        = fifo_wren & last_q;
  assign rx_err         = err_q | wr_block;
  assign fifo_din       = word_q;
  assign rx_data_length = rx_done ? pay_len_q : data_len_q;
  assign rx_state       = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pay_cnt_d  = pay_cnt_q;
    pay_len_d  = pay_len_q;
    data_len_d = rx_data_length;
    sh_d       = sh_q;
    word_d     = word_q;
    wr_pend_d  = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    acc_d      = acc_q;
    hi_d       = hi_q;
    mac_ok_d   = mac_ok_q;
    bc_ok_d    = bc_ok_q;
    ok_d       = ok_q;

    byte_ok = rx_dv & ~rx_er;
    cnt_inc = cnt_q + 5'd1;
    pay_inc = pay_cnt_q + 16'd1;
    shifted = {sh_q, rxd};
    csum    = acc_q + {4'h0, hi_q, rxd};
    fold1   = {1'b0, csum[15:0]} + {13'h0, csum[19:16]};
    fold2   = fold1[15:0] + {15'h0, fold1[16]};

    case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          if (rxd == 8'h55) begin
            state_d = S_PREAMBLE;
            cnt_d   = 5'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!rx_dv)            state_d = S_IDLE;
        else if (rx_er)        state_d = S_DROP;
        else if (rxd == 8'h55) begin
          if (cnt_q == 5'd7) state_d = S_DROP;
          else               cnt_d   = cnt_inc;
        end else if (rxd == 8'hD5) begin
          state_d  = S_ETH;
          cnt_d    = 5'd0;
          mac_ok_d = 1'b1;
          bc_ok_d  = 1'b1;
          ok_d     = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end

      S_ETH: begin
        if (!byte_ok) begin
          state_d = rx_dv ? S_DROP : S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q < 5'd6) begin
            mac_ok_d = mac_ok_q & (rxd == mac_byte(cnt_q[2:0]));
            bc_ok_d  = bc_ok_q & (rxd == 8'hFF);
          end
          if (cnt_q == 5'd12) ok_d = ok_q & (rxd == 8'h08);
          if (cnt_q == 5'd13) begin
            if ((mac_ok_q | bc_ok_q) & ok_q & (rxd == 8'h00)) begin
              state_d = S_IPHDR;
              cnt_d   = 5'd0;
              acc_d   = 20'h0;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end

      S_IPHDR: begin
        if (!byte_ok) begin
          state_d = rx_dv ? S_DROP : S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          // Even bytes hold the high half of the next 16-bit checksum word.
          if (!cnt_q[0]) hi_d  = rxd;
          else           acc_d = csum;
          if (cnt_q == 5'd0)  ok_d = ok_q & (rxd == 8'h45);
          if (cnt_q == 5'd9)  ok_d = ok_q & (rxd == 8'h11);
          if (cnt_q >= 5'd16) ok_d = ok_q & (rxd == ip_byte(cnt_q[1:0]));
          if (cnt_q == 5'd19) begin
            if (ok_q & (rxd == ip_byte(cnt_q[1:0])) & (fold2 == 16'hFFFF)) begin
              state_d = S_UDPHDR;
              cnt_d   = 5'd0;
              ok_d    = 1'b1;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end

      S_UDPHDR: begin
        if (!byte_ok) begin
          state_d = rx_dv ? S_DROP : S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (!cnt_q[0]) hi_d = rxd;
          if (cnt_q == 5'd2) ok_d = ok_q & (rxd == LOCAL_PORT[15:8]);
          if (cnt_q == 5'd3) ok_d = ok_q & (rxd == LOCAL_PORT[7:0]);
          if (cnt_q == 5'd5) begin
            ok_d      = ok_q & ({hi_q, rxd} >= 16'd9);
            pay_len_d = {hi_q, rxd} - 16'd8;
          end
          if (cnt_q == 5'd7) begin
            if (ok_q) begin
              state_d   = S_DATA;
              pay_cnt_d = 16'd0;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end

      S_DATA: begin
        if (wr_block) begin
          state_d = rx_dv ? S_DROP : S_IDLE;
        end else if (!byte_ok) begin
          err_d   = 1'b1;
          state_d = rx_dv ? S_DROP : S_IDLE;
        end else begin
          pay_cnt_d = pay_inc;
          sh_d      = shifted[23:0];
          if (pay_inc == pay_len_q) begin
            // Final byte: flush the word left-aligned, zero-padding missing low bytes.
            wr_pend_d = 1'b1;
            last_d    = 1'b1;
            state_d   = S_DROP;
            case (pay_inc[1:0])
              2'd0:    word_d = shifted;
              2'd1:    word_d = {shifted[7:0], 24'h0};
              2'd2:    word_d = {shifted[15:0], 16'h0};
              default: word_d = {shifted[23:0], 8'h0};
            endcase
          end else if (pay_inc[1:0] == 2'd0) begin
            wr_pend_d = 1'b1;
            word_d    = shifted;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      pay_cnt_q  <= 16'd0;
      pay_len_q  <= 16'd0;
      data_len_q <= 16'd0;
      sh_q       <= 24'h0;
      word_q     <= 32'h0;
      wr_pend_q  <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= 20'h0;
      hi_q       <= 8'h0;
      mac_ok_q   <= 1'b0;
      bc_ok_q    <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      pay_len_q  <= pay_len_d;
      data_len_q <= data_len_d;
      sh_q       <= sh_d;
      word_q     <= word_d;
      wr_pend_q  <= wr_pend_d;
      last_q     <= last_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      mac_ok_q   <= mac_ok_d;
      bc_ok_q    <= bc_ok_d;
      ok_q       <= ok_d;
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// Bench for udp_rx: builds frames from header fields, predicts writes/done/err from the
// frame description and checks them through a scoreboard queue.
module tb_udp_rx;
  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [15:0] LPORT = 16'h1F90;
  localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, rx_dv = 1'b0, rx_er = 1'b0, fifo_full = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic [31:0] fifo_din;
  logic        fifo_wren, rx_done, rx_err;
  logic [15:0] rx_data_length;
  logic [3:0]  rx_state;

  udp_rx dut (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .fifo_din(fifo_din), .fifo_wren(fifo_wren), .fifo_full(fifo_full),
    .rx_data_length(rx_data_length), .rx_done(rx_done), .rx_err(rx_err), .rx_state(rx_state)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [31:0] val; } ev_t;
  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  bit  mon_on = 1'b0;
  int  last_len = 0;

  // Frame description
  logic [47:0] f_dmac;
  logic [15:0] f_etype, f_dport, f_ulen;
  logic [7:0]  f_ver, f_proto;
  logic [31:0] f_dip;
  bit          f_badcs;
  int          f_npre, f_cut, f_cut_at, f_full_word, f_rst_at;
  logic [7:0]  pay[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_ev(input int k, input logic [31:0] v, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event actual=%h required=none", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("FAIL %s actual kind=%0d val=%h required kind=%0d val=%h", nm, k, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (fifo_wren) check_ev(EV_WR, fifo_din, "fifo_write");
      if (rx_done)   check_ev(EV_DONE, {16'h0, rx_data_length}, "rx_done");
      if (rx_err)    check_ev(EV_ERR, 32'h0, "rx_err");
    end
  end

  function automatic logic [31:0] word_of(input int k, input int len);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++)
      if (4*(k-1)+b < len) r[31-8*b -: 8] = pay[4*(k-1)+b];
    return r;
  endfunction

  task automatic push(input int k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic set_good(input int len);
    f_dmac = LMAC; f_etype = 16'h0800; f_ver = 8'h45; f_proto = 8'h11; f_dip = LIP;
    f_badcs = 1'b0; f_dport = LPORT; f_ulen = 16'(len + 8); f_npre = 7;
    f_cut = 0; f_cut_at = 0; f_full_word = 0; f_rst_at = 0;
    pay = {};
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic run_frame();
    logic [7:0]  w[$];
    logic [7:0]  ip[20];
    logic [31:0] s;
    logic [15:0] cs;
    int p0, len, lim, hi, full_pos, rst_pos, cut_pos, total;
    bit acc;
    p0 = f_npre + 43;
    w = {};
    repeat (f_npre) w.push_back(8'h55);
    w.push_back(8'hD5);
    for (int i = 0; i < 6; i++) w.push_back(f_dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) w.push_back(8'($urandom));
    w.push_back(f_etype[15:8]); w.push_back(f_etype[7:0]);
    ip[0] = f_ver; ip[1] = 8'h00; {ip[2], ip[3]} = 16'(20 + f_ulen);
    ip[4] = 8'($urandom); ip[5] = 8'($urandom); ip[6] = 8'h40; ip[7] = 8'h00;
    ip[8] = 8'h40; ip[9] = f_proto; ip[10] = 8'h00; ip[11] = 8'h00;
    for (int i = 12; i < 16; i++) ip[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ip[16+i] = f_dip[31-8*i -: 8];
    s = 32'h0;
    for (int i = 0; i < 10; i++) s = s + {16'h0, ip[2*i], ip[2*i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    if (f_badcs) cs = cs + 16'd1;
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    for (int i = 0; i < 20; i++) w.push_back(ip[i]);
    w.push_back(8'($urandom)); w.push_back(8'($urandom));
    w.push_back(f_dport[15:8]); w.push_back(f_dport[7:0]);
    w.push_back(f_ulen[15:8]);  w.push_back(f_ulen[7:0]);
    w.push_back(8'($urandom)); w.push_back(8'($urandom));
    foreach (pay[i]) w.push_back(pay[i]);
    if (f_cut == 1) begin
      while (w.size() > p0 + f_cut_at) void'(w.pop_back());
    end else begin
      repeat ($urandom_range(4, 8)) w.push_back(8'($urandom));
    end

    // Reference: accepted frames produce one write per 4 payload bytes plus a padded tail.
    acc = ((f_dmac == LMAC) || (f_dmac == 48'hFFFFFFFFFFFF)) && f_etype == 16'h0800 &&
          f_ver == 8'h45 && f_proto == 8'h11 && f_dip == LIP && !f_badcs &&
          f_dport == LPORT && f_ulen >= 16'd9 && f_npre >= 1 && f_npre <= 7;
    full_pos = -1; rst_pos = -1; cut_pos = -1;
    if (acc) begin
      len = int'(f_ulen) - 8;
      lim = (f_cut != 0) ? f_cut_at : len;
      if (f_rst_at > 0) begin
        rst_pos = p0 + f_rst_at;
        for (int k = 1; 4*k <= f_rst_at; k++) push(EV_WR, word_of(k, len));
        last_len = 0;
      end else begin
        for (int k = 1; k <= (len + 3) / 4; k++) begin
          hi = (4*k < len) ? 4*k : len;
          if (k == f_full_word) begin
            full_pos = p0 + hi;
            push(EV_ERR, 32'h0);
            break;
          end
          if (hi <= lim) begin
            push(EV_WR, word_of(k, len));
            if (hi == len) begin
              push(EV_DONE, 32'(len));
              last_len = len;
            end
          end else begin
            push(EV_ERR, 32'h0);
            break;
          end
        end
      end
      if (f_cut == 2) cut_pos = p0 + f_cut_at;
    end

    total = w.size() + 4;
    for (int p = 0; p < total; p++) begin
      @(posedge clk); #1;
      rx_dv     = (p < w.size());
      rxd       = rx_dv ? w[p] : 8'($urandom);
      rx_er     = (p == cut_pos);
      fifo_full = (p == full_pos) || (p < p0 && $urandom_range(0, 3) == 0);
      reset_n   = (p != rst_pos);
      if (rst_pos >= 0 && p == rst_pos + 1) begin
        @(negedge clk);
        cmp("rst_fifo_din", fifo_din, 32'h0);
        cmp("rst_strobes", {29'h0, fifo_wren, rx_done, rx_err}, 32'h0);
        cmp("rst_length", {16'h0, rx_data_length}, 32'h0);
        cmp("rst_state", {28'h0, rx_state}, 32'h0);
      end
    end
    @(negedge clk);
    cmp("idle_after_frame", {28'h0, rx_state}, 32'h0);
    cmp("events_pending", exp_q.size(), 32'h0);
    exp_q = {};
  endtask

  initial begin
    int len;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_fifo_din", fifo_din, 32'h0);
    cmp("reset_strobes", {29'h0, fifo_wren, rx_done, rx_err}, 32'h0);
    cmp("reset_length", {16'h0, rx_data_length}, 32'h0);
    cmp("reset_state", {28'h0, rx_state}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_on  = 1'b1;

    set_good(16);
    for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
    run_frame();
    cmp("len_16", {16'h0, rx_data_length}, 32'd16);

    set_good(5);
    pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_frame();
    cmp("len_5", {16'h0, rx_data_length}, 32'd5);

    set_good(12); f_badcs = 1'b1;          run_frame();
    set_good(12); f_dport = 16'h1F91;      run_frame();
    set_good(9);  f_dmac = 48'hFFFFFFFFFFFF; run_frame();
    set_good(12); f_dmac = 48'h000A3501FEC1; run_frame();
    set_good(12); f_etype = 16'h0806;      run_frame();
    cmp("len_after_drops", {16'h0, rx_data_length}, 32'd9);

    set_good(16); f_cut = 1; f_cut_at = 6; run_frame();
    set_good(7);                           run_frame();
    set_good(16); f_full_word = 2;         run_frame();
    set_good(16); f_rst_at = 6;            run_frame();
    set_good(3);  f_npre = 1;              run_frame();

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 40);
      set_good(len);
      if ($urandom_range(0, 3) == 0) f_dmac = 48'hFFFFFFFFFFFF;
      f_npre = $urandom_range(1, 7);
      case ($urandom_range(0, 15))
        0:  f_dmac  = f_dmac ^ (48'h1 << $urandom_range(0, 47));
        1:  f_etype = 16'h0806;
        2:  f_ver   = 8'h46;
        3:  f_proto = 8'h06;
        4:  f_dip   = f_dip ^ (32'h1 << $urandom_range(0, 31));
        5:  f_badcs = 1'b1;
        6:  f_dport = f_dport + 16'd1;
        7:  f_ulen  = 16'($urandom_range(0, 8));
        8:  f_npre  = 8;
        9:  begin f_cut = 1; f_cut_at = $urandom_range(0, len - 1); end
        10: begin f_cut = 2; f_cut_at = $urandom_range(0, len - 1); end
        11: f_full_word = $urandom_range(1, (len + 3) / 4);
        default: ;
      endcase
      run_frame();
    end
    cmp("final_length", {16'h0, rx_data_length}, 32'(last_len));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
